ram_rd_streamer: RTL and testbench

//  Read initiator for ram_1r1w_sync_backpressure. Accepts a (base address, length) command,

---
 rtl/ram_rd_streamer.sv | 160 ++++++++++++++++
 tb/tb_ram_rd_streamer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer
//   Read initiator for a 1R1W synchronous RAM that has a backpressured response
//   register. It takes a (base address, length) command and issues one read
//   request per element, stepping the address and wrapping it to 0 after els_p-1.
//   The read data goes out as a val/rdy stream with a last flag.
//   Sustained throughput is one beat per cycle.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset (the RAM shares it)
//   cmd_*          command input; cmd_len == 0 is legal and produces no beats
//   rd_req_*       read request channel to the RAM
//   rd_resp_*      read response channel from the RAM (passed straight through)
//   data_*         output stream; data_last marks the final beat of a command
//   done           one-cycle pulse after a command has been fully delivered
module ram_rd_streamer #(
  parameter int width_p  = 32,  // must equal the RAM width
  parameter int els_p    = 16,  // RAM depth; addresses wrap modulo els_p
  parameter int addr_w_p = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int len_w_p  = 16
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                cmd_val,
  input  logic [addr_w_p-1:0] cmd_addr,
  input  logic [len_w_p-1:0]  cmd_len,
  output logic                cmd_rdy,

  output logic                rd_req_val,
  output logic [addr_w_p-1:0] rd_req_addr,
  input  logic                rd_req_rdy,

  input  logic                rd_resp_val,
  input  logic [width_p-1:0]  rd_resp_data,
  output logic                rd_resp_rdy,

  output logic                data_val,
  output logic [width_p-1:0]  data_data,
  output logic                data_last,
  input  logic                data_rdy,

  output logic                done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [addr_w_p-1:0] last_addr_lp = addr_w_p'(els_p - 1);
  localparam logic [addr_w_p:0]   els_lim_lp   = (addr_w_p + 1)'(els_p);
  localparam logic [len_w_p-1:0]  one_lp       = len_w_p'(1);

  state_e                state_q,    state_d;
  logic [len_w_p-1:0]    req_cnt_q,  req_cnt_d;
  logic [len_w_p-1:0]    resp_cnt_q, resp_cnt_d;
  logic [addr_w_p-1:0]   req_addr_q, req_addr_d;
  logic [len_w_p-1:0]    len_q,      len_d;
  logic                  done_q,     done_d;

  logic cmd_fire;
  logic req_fire;
  logic beat_fire;

  // Outputs. The response path is pure wiring. While data_rdy is low, the RAM's
  // response register holds the beat. That register also lowers rd_req_rdy, so
  // request issue stalls on its own and no skid buffer is needed here.
  assign cmd_rdy      = (state_q == IDLE);
  assign rd_req_val   = (state_q == RUN) && (req_cnt_q != len_q);
  assign rd_req_addr  = req_addr_q;
  assign data_val     = rd_resp_val;
  assign data_data    = rd_resp_data;
  assign rd_resp_rdy  = data_rdy;
  assign data_last    = data_val && (resp_cnt_q == len_q - one_lp);
  assign done         = done_q;

  assign cmd_fire  = cmd_val && cmd_rdy;
  assign req_fire  = rd_req_val && rd_req_rdy;
  assign beat_fire = data_val && data_rdy;

  // NOTE: every signal driven here is assigned a default first. This means no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    req_addr_d = req_addr_q;
    len_d      = len_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          req_addr_d = cmd_addr;
          len_d      = cmd_len;
          req_cnt_d  = '0;
          resp_cnt_d = '0;
          if (cmd_len != '0) begin
            state_d = RUN;
          end else begin
            // Empty command: nothing to fetch, so report completion at once.
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (req_fire) begin
          req_cnt_d  = req_cnt_q + one_lp;
          req_addr_d = (req_addr_q == last_addr_lp) ? '0 : req_addr_q + addr_w_p'(1);
        end
        if (beat_fire) begin
          resp_cnt_d = resp_cnt_q + one_lp;
          // All requests have already been issued when the last beat leaves.
          // So returning to IDLE cannot strand an outstanding response.
          if (data_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. This makes every
  // register sample its next-state value from the same clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      req_addr_q <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      req_addr_q <= req_addr_d;
      len_q      <= len_d;
      done_q     <= done_d;
    end
  end

`ifndef SYNTHESIS
  // A response arriving while idle would mean the RAM and this block disagree
  // about what is in flight.
  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !rd_resp_val);

  a_req_ge_resp: assert property (@(posedge clk) disable iff (rst)
    req_cnt_q >= resp_cnt_q);

  a_cmd_addr_in_range: assert property (@(posedge clk) disable iff (rst)
    cmd_fire |-> ({1'b0, cmd_addr} < els_lim_lp));
`endif

endmodule

// File: tb/tb_ram_rd_streamer.sv
// tb_ram_rd_streamer
//   Testbench for ram_rd_streamer. A small behavioural model of the backpressured
//   synchronous RAM is paired with the DUT; it holds mem[i] = i + 100 with 16
//   entries of 32 bits.
//   The data expected for each command is queued when the command is driven.
//   Output beats are popped from that queue and compared as they handshake.
module tb_ram_rd_streamer;

  localparam int W   = 32;
  localparam int ELS = 16;
  localparam int AW  = 4;
  localparam int LW  = 16;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          cmd_val;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_rdy;
  logic          rd_req_val;
  logic [AW-1:0] rd_req_addr;
  logic          rd_req_rdy;
  logic          rd_resp_val;
  logic [W-1:0]  rd_resp_data;
  logic          rd_resp_rdy;
  logic          data_val;
  logic [W-1:0]  data_data;
  logic          data_last;
  logic          data_rdy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  beat_t         sb[$];
  int            beat_cycles[$];
  logic [AW-1:0] req_addrs[$];
  int            stall_seen = 0;
  bit            stall_pend = 0;
  logic [AW-1:0] stall_addr;

  ram_rd_streamer #(
    .width_p (W),
    .els_p   (ELS),
    .addr_w_p(AW),
    .len_w_p (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_val     (cmd_val),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_rdy     (cmd_rdy),
    .rd_req_val  (rd_req_val),
    .rd_req_addr (rd_req_addr),
    .rd_req_rdy  (rd_req_rdy),
    .rd_resp_val (rd_resp_val),
    .rd_resp_data(rd_resp_data),
    .rd_resp_rdy (rd_resp_rdy),
    .data_val    (data_val),
    .data_data   (data_data),
    .data_last   (data_last),
    .data_rdy    (data_rdy),
    .done        (done)
  );

  // RAM model: a single response register. It accepts a new read when empty or
  // when its current beat is being taken.
  logic         resp_val_q;
  logic [W-1:0] resp_data_q;

  assign rd_req_rdy   = !resp_val_q || rd_resp_rdy;
  assign rd_resp_val  = resp_val_q;
  assign rd_resp_data = resp_data_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_val_q  <= 1'b0;
      resp_data_q <= '0;
    end else if (rd_req_val && rd_req_rdy) begin
      resp_val_q  <= 1'b1;
      resp_data_q <= W'(rd_req_addr) + W'(100);
    end else if (rd_resp_rdy) begin
      resp_val_q  <= 1'b0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: runs 2 time units after each falling edge, once inputs have settled.
  // It checks every beat against the scoreboard, logs issued request addresses,
  // and checks that a stalled request holds its address.
  always @(negedge clk) begin
    beat_t exp_b;
    #2;
    if (!rst) begin
      if (data_val && data_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data=%0d last=%0b, expected no beat", data_data, data_last);
        end else begin
          exp_b = sb.pop_front();
          if (data_data !== exp_b.data || data_last !== exp_b.last) begin
            errors++;
            $display("FAIL beat: got data=%0d last=%0b, expected data=%0d last=%0b",
                     data_data, data_last, exp_b.data, exp_b.last);
          end
        end
        beat_cycles.push_back(cyc);
      end
      if (rd_req_val && rd_req_rdy) req_addrs.push_back(rd_req_addr);
      if (stall_pend) begin
        checks++;
        if (rd_req_val !== 1'b1 || rd_req_addr !== stall_addr) begin
          errors++;
          $display("FAIL req_stall_hold: got val=%0b addr=%0d, expected val=1 addr=%0d",
                   rd_req_val, rd_req_addr, stall_addr);
        end
      end
      stall_pend = rd_req_val && !rd_req_rdy;
      if (stall_pend) begin
        stall_addr = rd_req_addr;
        stall_seen++;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic push_expected(input int a, input int l);
    beat_t b;
    for (int i = 0; i < l; i++) begin
      b.data = W'(((a + i) % ELS) + 100);
      b.last = (i == l - 1);
      sb.push_back(b);
    end
  endtask

  // Issue one command and wait for its done pulse. n is the cycle in which the
  // command handshake happens; d is the cycle in which done is seen.
  task automatic run_cmd(input int a, input int l, input bit toggle, output int n, output int d);
    bit acc = 1'b0;
    n = -1;
    d = -1;
    push_expected(a, l);
    beat_cycles.delete();
    req_addrs.delete();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      data_rdy = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      cmd_val  = !acc;
      cmd_addr = AW'(a);
      cmd_len  = LW'(l);
      #1;
      if (acc && done) begin
        d = cyc;
        break;
      end
      if (!acc && cmd_rdy) begin
        acc = 1'b1;
        n   = cyc;
      end
    end
    if (d < 0) begin
      checks++;
      errors++;
      $display("FAIL run_cmd_timeout: addr=%0d len=%0d, no done pulse seen", a, l);
    end
    @(negedge clk);
    cmd_val  = 1'b0;
    data_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    cmd_val  = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    data_rdy = 1'b1;
    #1;
    checks++;
    if (cmd_rdy !== 1'b1 || rd_req_val !== 1'b0 || data_val !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_in: got cmd_rdy=%0b req_val=%0b data_val=%0b done=%0b, expected 1 0 0 0",
               cmd_rdy, rd_req_val, data_val, done);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (cmd_rdy !== 1'b1 || rd_req_val !== 1'b0 || data_val !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: got cmd_rdy=%0b req_val=%0b data_val=%0b done=%0b, expected 1 0 0 0",
               cmd_rdy, rd_req_val, data_val, done);
    end
  endtask

  task automatic test_basic();
    int n, d;
    run_cmd(2, 4, 1'b0, n, d);
    checks++;
    if (beat_cycles.size() != 4) begin
      errors++;
      $display("FAIL basic_beat_count: got %0d, expected 4", beat_cycles.size());
    end
    for (int i = 0; i < beat_cycles.size() && i < 4; i++) begin
      checks++;
      if (beat_cycles[i] != n + 2 + i) begin
        errors++;
        $display("FAIL basic_beat_cycle[%0d]: got %0d, expected %0d", i, beat_cycles[i], n + 2 + i);
      end
    end
    checks++;
    if (d != n + 6) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d, expected %0d", d, n + 6);
    end
    #1;
    checks++;
    if (done !== 1'b0 || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_width: got done=%0b cmd_rdy=%0b, expected done=0 cmd_rdy=1", done, cmd_rdy);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_leftover: got %0d beats undelivered, expected 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    int n, d;
    logic [AW-1:0] exp_addr[4];
    exp_addr[0] = 4'd14;
    exp_addr[1] = 4'd15;
    exp_addr[2] = 4'd0;
    exp_addr[3] = 4'd1;
    run_cmd(14, 4, 1'b0, n, d);
    checks++;
    if (req_addrs.size() != 4) begin
      errors++;
      $display("FAIL wrap_req_count: got %0d, expected 4", req_addrs.size());
    end
    for (int i = 0; i < req_addrs.size() && i < 4; i++) begin
      checks++;
      if (req_addrs[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_req_addr[%0d]: got %0d, expected %0d", i, req_addrs[i], exp_addr[i]);
      end
    end
    checks++;
    if (sb.size() != 0 || beat_cycles.size() != 4) begin
      errors++;
      $display("FAIL wrap_beats: got %0d beats and %0d undelivered, expected 4 and 0",
               beat_cycles.size(), sb.size());
    end
  endtask

  task automatic test_backpressure();
    int n, d;
    stall_seen = 0;
    run_cmd(2, 4, 1'b1, n, d);
    checks++;
    if (beat_cycles.size() != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_beats: got %0d beats and %0d undelivered, expected 4 and 0",
               beat_cycles.size(), sb.size());
    end
    checks++;
    if (stall_seen == 0) begin
      errors++;
      $display("FAIL bp_stall: got %0d stalled request cycles, expected at least 1", stall_seen);
    end
    checks++;
    if (d <= n + 6) begin
      errors++;
      $display("FAIL bp_done_cycle: got %0d, expected later than %0d", d, n + 6);
    end
  endtask

  task automatic test_zero_len();
    int n, d;
    run_cmd(3, 0, 1'b0, n, d);
    checks++;
    if (d != n + 1) begin
      errors++;
      $display("FAIL zero_done_cycle: got %0d, expected %0d", d, n + 1);
    end
    checks++;
    if (beat_cycles.size() != 0 || req_addrs.size() != 0) begin
      errors++;
      $display("FAIL zero_activity: got %0d beats and %0d requests, expected 0 and 0",
               beat_cycles.size(), req_addrs.size());
    end
    #1;
    checks++;
    if (cmd_rdy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: got cmd_rdy=%0b done=%0b, expected 1 0", cmd_rdy, done);
    end
  endtask

  task automatic test_back_to_back();
    bit acc1 = 1'b0;
    bit acc2 = 1'b0;
    int n1 = -1;
    int n2 = -1;
    int d1 = -1;
    int d2 = -1;
    push_expected(0, 3);
    push_expected(8, 2);
    beat_cycles.delete();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      data_rdy = 1'b1;
      cmd_val  = !acc2;
      cmd_addr = acc1 ? AW'(8) : AW'(0);
      cmd_len  = acc1 ? LW'(2) : LW'(3);
      #1;
      if (acc1 && done && d1 < 0) d1 = cyc;
      if (acc2 && done && cyc > n2) begin
        d2 = cyc;
        break;
      end
      if (cmd_rdy && !acc2) begin
        if (!acc1) begin
          acc1 = 1'b1;
          n1   = cyc;
        end else begin
          acc2 = 1'b1;
          n2   = cyc;
        end
      end
    end
    @(negedge clk);
    cmd_val = 1'b0;
    checks++;
    if (d2 < 0) begin
      errors++;
      $display("FAIL b2b_timeout: got d1=%0d d2=%0d, expected both done pulses", d1, d2);
    end
    checks++;
    if (d1 != n1 + 5 || n2 != d1) begin
      errors++;
      $display("FAIL b2b_accept: got done1=%0d accept2=%0d, expected done1=%0d accept2=%0d",
               d1, n2, n1 + 5, n1 + 5);
    end
    checks++;
    if (beat_cycles.size() != 5 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_beats: got %0d beats and %0d undelivered, expected 5 and 0",
               beat_cycles.size(), sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, d;
    bit hit = 1'b0;
    push_expected(2, 4);
    beat_cycles.delete();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      data_rdy = 1'b1;
      cmd_val  = (k == 0);
      cmd_addr = AW'(2);
      cmd_len  = LW'(4);
      #1;
      if (beat_cycles.size() >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    cmd_val = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_progress: got %0d beats, expected 2 before reset", beat_cycles.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (data_val !== 1'b0 || rd_req_val !== 1'b0 || cmd_rdy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: got data_val=%0b req_val=%0b cmd_rdy=%0b done=%0b, expected 0 0 1 0",
               data_val, rd_req_val, cmd_rdy, done);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_rdy !== 1'b1 || data_val !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: got cmd_rdy=%0b data_val=%0b, expected 1 0", cmd_rdy, data_val);
    end
    run_cmd(5, 1, 1'b0, n, d);
    checks++;
    if (beat_cycles.size() != 1 || sb.size() != 0 || d != n + 3) begin
      errors++;
      $display("FAIL rstmid_new_cmd: got %0d beats, %0d undelivered, done at %0d, expected 1, 0, %0d",
               beat_cycles.size(), sb.size(), d, n + 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
